sprite_layer_compositor: RTL and testbench
==========================================

Name: sprite_layer_compositor

Overview:
Parametrised, pipelined successor to the fixed-priority colour mux that drives VGA RGB. It merges NL sprite layers by priority with colour-key transparency, so a transparent pixel falls through to lower layers. A frame-synchronous mode FSM (splash / play / game-over flash) overrides the composite. It also reports per-frame sprite overlap against layer 0 (player ship) for the game logic.

Parameters:
NL, 4, number of layers; layer 0 = highest priority (player ship)
CW, 8, bits per colour channel
KEY_RGB, 24'h000000, colour key; an opaque-flagged pixel equal to this is transparent
BG_RGB, 24'h000000, background colour when no layer is opaque
SPLASH_RGB, 24'hAF00A0, splash fill colour
OVER_RGB, 24'hAF0000, game-over fill colour
FLASH_FRAMES, 8, frames per flash phase
FLASH_PHASES, 6, flash phases before the hold state

Ports:
Clk  in  1  system clock
Reset  in  1  synchronous, active-high reset
frame_start  in  1  one-cycle pulse at start of vertical blank
pix_valid  in  1  DrawX/DrawY inside the visible area this cycle
LayerOn  in  NL  layer k covers the current pixel
LayerRGB  in  NL*3*CW  layer k colour at bits [k*3*CW +: 3*CW], ordered {R,G,B}
SplashScreen  in  1  level request for splash mode
GameOver  in  1  level request for game-over mode
Red, Green, Blue  out  CW each  registered pixel colour
out_valid  out  1  pix_valid delayed 2 cycles
HitLayer  out  $clog2(NL)  index of the winning layer (0 if background)
HitBg  out  1  no layer is opaque at this pixel
FrameCollision  out  NL  overlap mask for the previous frame; bit 0 is always 0
Mode  out  2  0=SPLASH, 1=PLAY, 2=OVER_FLASH, 3=OVER_HOLD

Behaviour:
- Reset (synchronous, active-high): Mode=SPLASH; Red/Green/Blue=0; out_valid=0; HitLayer=0; HitBg=1; FrameCollision=0; collision accumulator=0; flash counters=0; both pipeline stages cleared.
- Opaque[k] = LayerOn[k] && (LayerRGB slice != KEY_RGB).
- Stage 1 (cycle n+1): register the Opaque vector, layer colours, and pix_valid.
- Stage 2 (cycle n+2): the winner is the lowest k with Opaque[k]; otherwise BG_RGB with HitBg=1. Mode override is applied, and all outputs are registered. Total latency is exactly 2 cycles.
- While out_valid=0, RGB=0 in every mode (blanking).
- Mode FSM. The mode requests are sampled only in cycles where frame_start=1:
  - SPLASH -> PLAY when SplashScreen=0.
  - PLAY -> OVER_FLASH when GameOver=1. On entry, flash frame counter=0 and phase counter=0.
  - OVER_FLASH: the frame counter increments on each frame_start. At FLASH_FRAMES-1 it wraps to 0 and the phase counter increments. After FLASH_PHASES phases complete -> OVER_HOLD.
  - OVER_FLASH or OVER_HOLD -> SPLASH when SplashScreen=1; otherwise they stay while GameOver=1. If GameOver drops, -> PLAY.
  - From any state, SplashScreen=1 at frame_start -> SPLASH. SplashScreen has priority over GameOver.
- Output per mode:
  - SPLASH: SPLASH_RGB.
  - PLAY: composite.
  - OVER_FLASH: OVER_RGB on even phases, composite on odd phases.
  - OVER_HOLD: OVER_RGB.
  - HitLayer/HitBg always reflect the composite, regardless of mode.
- The mode is applied at stage 2, so a change takes effect on the pixel that stage 2 outputs in the cycle after the frame_start edge.
- Collision, evaluated at stage 1:
  - In PLAY with pix_valid=1, set acc[k] |= Opaque[0] && Opaque[k] for k>=1.
  - On frame_start: FrameCollision <= acc, and acc is cleared.
  - If frame_start coincides with an overlapping pixel, that pixel is ORed into the new, cleared accumulator, not the reported value.
  - In non-PLAY modes the accumulator does not update.
- All colour arithmetic is a pure select; there is no blending and no width growth.

Test Plan:
- Reset held 3 cycles, then released with LayerOn=0 and pix_valid=1 -> Mode=0, RGB=AF/00/A0 from cycle 2, out_valid=1 two cycles after pix_valid.
- PLAY, LayerOn=4'b0110, layer1=112233, layer2=445566 -> RGB=11/22/33, HitLayer=1, exactly 2 cycles after input.
- PLAY, layer1 on with colour 000000 (key), layer2=445566 -> RGB=44/55/66, HitLayer=2. With all layers keyed -> BG_RGB and HitBg=1.
- PLAY, layer0 and layer3 opaque on one pixel; frame_start pulsed -> FrameCollision=4'b1000 after the pulse, then 0 after the next frame_start with no overlap. Overlap on the frame_start cycle itself -> reported only after the following frame_start.
- GameOver=1 from PLAY (FLASH_FRAMES=2, FLASH_PHASES=4) -> red for frames 0-1, composite for 2-3, red 4-5, composite 6-7, then Mode=3 solid AF0000. GameOver=0 at the next frame_start -> Mode=1.
- SplashScreen and GameOver both 1 at frame_start in PLAY -> Mode=0. Reset asserted mid-OVER_FLASH -> Mode=0, counters 0, outputs 0 the next cycle.

Source files
------------

// File: rtl/sprite_layer_compositor_if.sv
// Pixel, mode-request and composite-result bundle
// between the video timing/game logic and the compositor.
interface sprite_layer_compositor_if #(
  parameter int NL = 4,
  parameter int CW = 8
);
  localparam int HW = (NL > 1) ? $clog2(NL) : 1;

  logic              frame_start;
  logic              pix_valid;
  logic [NL-1:0]     LayerOn;
  logic [NL*3*CW-1:0] LayerRGB;
  logic              SplashScreen;
  logic              GameOver;
  logic [CW-1:0]     Red;
  logic [CW-1:0]     Green;
  logic [CW-1:0]     Blue;
  logic              out_valid;
  logic [HW-1:0]     HitLayer;
  logic              HitBg;
  logic [NL-1:0]     FrameCollision;
  logic [1:0]        Mode;

  modport master (
    output frame_start, pix_valid, LayerOn, LayerRGB,
    output SplashScreen, GameOver,
    input  Red, Green, Blue, out_valid,
    input  HitLayer, HitBg, FrameCollision, Mode
  );

  modport slave (
    input  frame_start, pix_valid, LayerOn, LayerRGB,
    input  SplashScreen, GameOver,
    output Red, Green, Blue, out_valid,
    output HitLayer, HitBg, FrameCollision, Mode
  );
endinterface

// File: rtl/sprite_layer_compositor.sv
// Two-stage priority compositor with colour-key transparency,
// frame-synchronous mode override and per-frame overlap report.
module sprite_layer_compositor #(
  parameter int NL = 4,
  parameter int CW = 8,
  parameter logic [3*CW-1:0] KEY_RGB = 24'h000000,
  parameter logic [3*CW-1:0] BG_RGB = 24'h000000,
  parameter logic [3*CW-1:0] SPLASH_RGB = 24'hAF00A0,
  parameter logic [3*CW-1:0] OVER_RGB = 24'hAF0000,
  parameter int FLASH_FRAMES = 8,
  parameter int FLASH_PHASES = 6
) (
  input logic Clk,
  input logic Reset,
  sprite_layer_compositor_if.slave bus
);
  localparam int PXW = 3 * CW;
  localparam int HW = (NL > 1) ? $clog2(NL) : 1;
  localparam int FW = $clog2(FLASH_FRAMES + 1);
  localparam int PW = $clog2(FLASH_PHASES + 1);

  typedef enum logic [1:0] {
    SPLASH     = 2'd0,
    PLAY       = 2'd1,
    OVER_FLASH = 2'd2,
    OVER_HOLD  = 2'd3
  } mode_t;

  mode_t mode, modeNext;
  logic [FW-1:0] flashFrame, frameNext;
  logic [PW-1:0] flashPhase, phaseNext;

  logic [NL-1:0] opaque;
  logic [NL-1:0] hits;
  logic [NL-1:0] acc;

  logic [NL-1:0] s1Opaque;
  logic [NL*PXW-1:0] s1Rgb;
  logic s1Valid;

  logic [HW-1:0] winIdx;
  logic winBg;
  logic [PXW-1:0] winRgb;
  logic [PXW-1:0] shown;

  assign bus.Mode = mode;

  // A covering layer is transparent when its colour equals the key
  always_comb begin
    opaque = '0;
    for (int k = 0; k < NL; k++)
      opaque[k] = bus.LayerOn[k] &&
        (bus.LayerRGB[k*PXW +: PXW] != KEY_RGB);
  end

  // Overlap of each lower layer with the player ship, live pixels in PLAY
  always_comb begin
    hits = '0;
    if (mode == PLAY && bus.pix_valid)
      for (int k = 1; k < NL; k++)
        hits[k] = opaque[0] && opaque[k];
  end

  // Stage 1: capture transparency vector, colours and pixel valid
  always_ff @(posedge Clk) begin
    if (Reset) begin
      s1Opaque <= '0;
      s1Rgb <= '0;
      s1Valid <= 1'b0;
    end else begin
      s1Opaque <= opaque;
      s1Rgb <= bus.LayerRGB;
      s1Valid <= bus.pix_valid;
    end
  end

  // Frame overlap accumulator; a hit on the frame_start cycle opens the new frame
  always_ff @(posedge Clk) begin
    if (Reset) begin
      acc <= '0;
      bus.FrameCollision <= '0;
    end else if (bus.frame_start) begin
      bus.FrameCollision <= acc;
      acc <= hits;
    end else begin
      acc <= acc | hits;
    end
  end

  // Highest-priority opaque layer wins; scan down so layer 0 lands last
  always_comb begin
    winIdx = '0;
    winBg = 1'b1;
    winRgb = BG_RGB;
    for (int k = NL - 1; k >= 0; k--) begin
      if (s1Opaque[k]) begin
        winIdx = HW'(k);
        winBg = 1'b0;
        winRgb = s1Rgb[k*PXW +: PXW];
      end
    end
  end

  // Mode override of the composite colour
  always_comb begin
    shown = winRgb;
    unique case (mode)
      SPLASH:     shown = SPLASH_RGB;
      PLAY:       shown = winRgb;
      OVER_FLASH: if (!flashPhase[0]) shown = OVER_RGB;
      OVER_HOLD:  shown = OVER_RGB;
    endcase
  end

  // Stage 2: registered pixel, blanked outside the visible area
  always_ff @(posedge Clk) begin
    if (Reset) begin
      {bus.Red, bus.Green, bus.Blue} <= '0;
      bus.out_valid <= 1'b0;
      bus.HitLayer <= '0;
      bus.HitBg <= 1'b1;
    end else begin
      {bus.Red, bus.Green, bus.Blue} <= s1Valid ? shown : '0;
      bus.out_valid <= s1Valid;
      bus.HitLayer <= winIdx;
      bus.HitBg <= winBg;
    end
  end

  // Mode state and flash counters
  always_ff @(posedge Clk) begin
    if (Reset) begin
      mode <= SPLASH;
      flashFrame <= '0;
      flashPhase <= '0;
    end else begin
      mode <= modeNext;
      flashFrame <= frameNext;
      flashPhase <= phaseNext;
    end
  end

  // Requests only act at frame_start; splash outranks game-over
  always_comb begin
    modeNext = mode;
    frameNext = flashFrame;
    phaseNext = flashPhase;
    if (bus.frame_start) begin
      if (bus.SplashScreen) begin
        modeNext = SPLASH;
      end else begin
        unique case (mode)
          SPLASH: modeNext = PLAY;
          PLAY: begin
            if (bus.GameOver) begin
              modeNext = OVER_FLASH;
              frameNext = '0;
              phaseNext = '0;
            end
          end
          OVER_FLASH: begin
            if (!bus.GameOver) begin
              modeNext = PLAY;
            end else if (flashFrame == FW'(FLASH_FRAMES - 1)) begin
              frameNext = '0;
              phaseNext = flashPhase + 1'b1;
              if (flashPhase == PW'(FLASH_PHASES - 1))
                modeNext = OVER_HOLD;
            end else begin
              frameNext = flashFrame + 1'b1;
            end
          end
          OVER_HOLD: if (!bus.GameOver) modeNext = PLAY;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_sprite_layer_compositor.sv
// Directed + randomized bench for sprite_layer_compositor
// against a frame-level behavioural model.
module tb_sprite_layer_compositor;
  localparam int NL = 4;
  localparam int CW = 8;
  localparam int FF = 2;
  localparam int FP = 4;
  localparam logic [23:0] KEY = 24'h000000;
  localparam logic [23:0] BG = 24'h000000;
  localparam logic [23:0] SPL = 24'hAF00A0;
  localparam logic [23:0] OVR = 24'hAF0000;

  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  sprite_layer_compositor_if #(.NL(NL), .CW(CW)) bus();

  sprite_layer_compositor #(
    .NL(NL), .CW(CW),
    .FLASH_FRAMES(FF), .FLASH_PHASES(FP)
  ) dut (
    .Clk(Clk),
    .Reset(Reset),
    .bus(bus.slave)
  );

  int tests = 0;
  int fails = 0;

  bit rstI, fsI, pvI, ssI, goI;
  logic [NL-1:0] onI;
  logic [NL*24-1:0] rgbI;

  int mSt;
  int overFrames;
  bit p1Valid, p1Bg;
  int p1Idx;
  logic [23:0] p1Rgb;
  logic [NL-1:0] acc;

  bit eValid, eBg;
  int eIdx, eMode;
  logic [23:0] eRgb;
  logic [NL-1:0] eColl;

  function automatic int modelMode();
    if (mSt == 2) return (overFrames >= FF * FP) ? 3 : 2;
    return mSt;
  endfunction

  function automatic bit opq(input int k);
    return onI[k] && (rgbI[k*24 +: 24] != KEY);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic modelStep();
    int md;
    bit nbg;
    int nidx;
    logic [23:0] nc;
    logic [NL-1:0] hits;
    if (rstI) begin
      mSt = 0; overFrames = 0;
      p1Valid = 0; p1Bg = 1; p1Idx = 0; p1Rgb = BG;
      acc = '0;
      eValid = 0; eBg = 1; eIdx = 0; eRgb = '0; eColl = '0;
    end else begin
      md = modelMode();
      eValid = p1Valid; eBg = p1Bg; eIdx = p1Idx;
      if (!p1Valid) eRgb = '0;
      else if (md == 0) eRgb = SPL;
      else if (md == 1) eRgb = p1Rgb;
      else if (md == 3 || ((overFrames / FF) % 2) == 0) eRgb = OVR;
      else eRgb = p1Rgb;
      hits = '0;
      if (md == 1 && pvI)
        for (int k = 1; k < NL; k++) hits[k] = opq(0) && opq(k);
      if (fsI) begin eColl = acc; acc = hits; end
      else acc = acc | hits;
      nbg = 1; nidx = 0; nc = BG;
      for (int k = 0; k < NL; k++)
        if (nbg && opq(k)) begin
          nbg = 0; nidx = k; nc = rgbI[k*24 +: 24];
        end
      p1Valid = pvI; p1Bg = nbg; p1Idx = nidx; p1Rgb = nc;
      if (fsI) begin
        if (ssI) mSt = 0;
        else if (mSt == 0) mSt = 1;
        else if (mSt == 1) begin
          if (goI) begin mSt = 2; overFrames = 0; end
        end
        else if (!goI) mSt = 1;
        else if (overFrames < FF * FP) overFrames++;
      end
    end
    eMode = modelMode();
  endtask

  task automatic tick();
    Reset = rstI;
    bus.frame_start = fsI;
    bus.pix_valid = pvI;
    bus.LayerOn = onI;
    bus.LayerRGB = rgbI;
    bus.SplashScreen = ssI;
    bus.GameOver = goI;
    @(posedge Clk);
    modelStep();
    #1;
    chk("mode", bus.Mode, eMode);
    chk("outValid", bus.out_valid, eValid);
    chk("rgb", {bus.Red, bus.Green, bus.Blue}, eRgb);
    chk("hitLayer", bus.HitLayer, eIdx);
    chk("hitBg", bus.HitBg, eBg);
    chk("frameColl", bus.FrameCollision, eColl);
  endtask

  task automatic frame();
    fsI = 1; tick(); fsI = 0;
  endtask

  task automatic randPix();
    pvI = ($urandom_range(0, 7) != 0);
    onI = NL'($urandom);
    for (int k = 0; k < NL; k++)
      rgbI[k*24 +: 24] = ($urandom_range(0, 3) == 0) ? KEY : 24'($urandom);
  endtask

  initial begin
    rstI = 1; fsI = 0; pvI = 0; ssI = 1; goI = 0;
    onI = '0; rgbI = '0;
    repeat (3) tick();
    chk("rstMode", bus.Mode, 0);
    chk("rstRgb", {bus.Red, bus.Green, bus.Blue}, 0);
    chk("rstHitBg", bus.HitBg, 1);

    rstI = 0; pvI = 1; onI = '0;
    tick();
    chk("lat1Valid", bus.out_valid, 0);
    tick();
    chk("splashRgb", {bus.Red, bus.Green, bus.Blue}, 24'hAF00A0);
    chk("splashValid", bus.out_valid, 1);

    ssI = 0; frame();
    tick();
    chk("playMode", bus.Mode, 1);

    onI = 4'b0110;
    rgbI = {24'hAAAAAA, 24'h445566, 24'h112233, 24'h999999};
    tick();
    chk("latNotYet", {bus.Red, bus.Green, bus.Blue} == 24'h112233, 0);
    tick();
    chk("prioRgb", {bus.Red, bus.Green, bus.Blue}, 24'h112233);
    chk("prioHit", bus.HitLayer, 1);

    rgbI = {24'hAAAAAA, 24'h445566, 24'h000000, 24'h999999};
    tick(); tick();
    chk("keyRgb", {bus.Red, bus.Green, bus.Blue}, 24'h445566);
    chk("keyHit", bus.HitLayer, 2);

    onI = 4'b1111; rgbI = '0;
    tick(); tick();
    chk("allKeyRgb", {bus.Red, bus.Green, bus.Blue}, BG);
    chk("allKeyBg", bus.HitBg, 1);

    repeat (150) begin
      randPix();
      fsI = ($urandom_range(0, 19) == 0);
      tick();
    end
    fsI = 0;

    pvI = 0; onI = '0; frame();
    pvI = 1; onI = 4'b1001;
    rgbI = {24'h123456, 24'h000000, 24'h000000, 24'h654321};
    tick();
    pvI = 0; onI = '0; tick();
    frame();
    chk("collRep", bus.FrameCollision, 4'b1000);
    frame();
    chk("collClr", bus.FrameCollision, 4'b0000);
    pvI = 1; onI = 4'b1001; fsI = 1; tick(); fsI = 0;
    chk("collEdgeNow", bus.FrameCollision, 4'b0000);
    pvI = 0; onI = '0; tick();
    frame();
    chk("collEdgeNext", bus.FrameCollision, 4'b1000);

    pvI = 1; onI = 4'b0010;
    rgbI = {24'h0, 24'h0, 24'h112233, 24'h0};
    goI = 1; frame();
    for (int f = 0; f < 8; f++) begin
      repeat (3) tick();
      chk("flashMode", bus.Mode, 2);
      chk("flashRgb", {bus.Red, bus.Green, bus.Blue},
          (((f / 2) % 2) == 0) ? OVR : 24'h112233);
      frame();
    end
    repeat (3) tick();
    chk("holdMode", bus.Mode, 3);
    chk("holdRgb", {bus.Red, bus.Green, bus.Blue}, OVR);
    goI = 0; frame();
    chk("resumeMode", bus.Mode, 1);

    ssI = 1; goI = 1; frame();
    chk("splashPrio", bus.Mode, 0);
    ssI = 0; goI = 0; frame();
    goI = 1; frame();
    repeat (3) begin tick(); frame(); end
    rstI = 1; tick();
    chk("midRstMode", bus.Mode, 0);
    chk("midRstRgb", {bus.Red, bus.Green, bus.Blue}, 0);
    chk("midRstValid", bus.out_valid, 0);
    rstI = 0; goI = 0; ssI = 0;

    repeat (300) begin
      randPix();
      fsI = ($urandom_range(0, 7) == 0);
      ssI = ($urandom_range(0, 5) == 0);
      goI = ($urandom_range(0, 3) != 0);
      rstI = ($urandom_range(0, 199) == 0);
      tick();
    end
    rstI = 0; fsI = 0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
